// File: rtl/efuse_prog_sequencer_if.sv
// ============================================================================
// Module  : efuse_prog_sequencer_if
// Purpose : Slow-control request and eFuse-controller signals for the sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

interface efuse_prog_sequencer_if;
  logic        req_prog;
  logic        req_read;
  logic [31:0] unlock_key;
  logic [31:0] prog_data;
  logic [3:0]  tckhp_cfg;
  logic [31:0] efuse_q;
  logic        ctrl_csb;
  logic        ctrl_short;
  logic        start;
  logic [1:0]  mode;
  logic [31:0] prog;
  logic [3:0]  TCKHP;
  logic        busy;
  logic        done;
  logic [1:0]  err;
  logic [31:0] rd_data;
  logic        prog_locked;

  modport master (
    output req_prog, req_read, unlock_key, prog_data, tckhp_cfg,
           efuse_q, ctrl_csb, ctrl_short,
    input  start, mode, prog, TCKHP, busy, done, err, rd_data, prog_locked
  );

  modport slave (
    input  req_prog, req_read, unlock_key, prog_data, tckhp_cfg,
           efuse_q, ctrl_csb, ctrl_short,
    output start, mode, prog, TCKHP, busy, done, err, rd_data, prog_locked
  );
endinterface

`default_nettype wire

// File: rtl/efuse_prog_sequencer.sv
// ============================================================================
// Module  : efuse_prog_sequencer
// Purpose : Key-protected one-shot program / read front-end for the eFuse controller
// Revision: 1.0
// ============================================================================
`default_nettype none

module efuse_prog_sequencer #(
  parameter logic [31:0] KEY        = 32'hE5F0_C0DE,
  parameter int          START_HOLD = 16,
  parameter int          RD_WINDOW  = 64,
  parameter int          TIMEOUT    = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  efuse_prog_sequencer_if.slave bus
);

  localparam logic [15:0] c_HOLD_LAST  = 16'(START_HOLD - 1);
  localparam logic [15:0] c_RD_LAST    = 16'(RD_WINDOW - 1);
  localparam logic [15:0] c_RDEND_LAST = 16'd1;
  localparam logic [15:0] c_TIMEOUT    = 16'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WR_HOLD    = 3'd1,
    S_WR_CSB_LO  = 3'd2,
    S_WR_CSB_HI  = 3'd3,
    S_WR_PWR_OFF = 3'd4,
    S_RD_HOLD    = 3'd5,
    S_RD_END     = 3'd6,
    S_DONE       = 3'd7
  } state_t;

  state_t      r_state;
  logic [15:0] r_cnt;
  logic        r_start;
  logic [1:0]  r_mode;
  logic [31:0] r_prog;
  logic [3:0]  r_tckhp;
  logic        r_busy;
  logic        r_done;
  logic [1:0]  r_err;
  logic [31:0] r_rd_data;
  logic        r_locked;

  logic        w_key_ok;
  logic        w_timeout;

  assign w_key_ok  = (bus.unlock_key == KEY) && (bus.prog_data != 32'h0);
  assign w_timeout = (r_cnt == c_TIMEOUT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= 16'h0;
      r_start   <= 1'b0;
      r_mode    <= 2'b00;
      r_prog    <= 32'h0;
      r_tckhp   <= 4'd4;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 2'b00;
      r_rd_data <= 32'h0;
      r_locked  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.req_prog && bus.req_read) begin
            r_err <= 2'b11;
          end else if (bus.req_prog) begin
            if (r_locked) begin
              r_err <= 2'b11;
            end else if (!w_key_ok) begin
              r_err <= 2'b01;
            end else begin
              r_err   <= 2'b00;
              r_prog  <= bus.prog_data;
              r_tckhp <= bus.tckhp_cfg;
              r_start <= 1'b1;
              r_mode  <= 2'b01;
              r_busy  <= 1'b1;
              r_cnt   <= 16'h0;
              r_state <= S_WR_HOLD;
            end
          end else if (bus.req_read) begin
            r_err   <= 2'b00;
            r_tckhp <= bus.tckhp_cfg;
            r_start <= 1'b0;
            r_mode  <= 2'b10;
            r_busy  <= 1'b1;
            r_cnt   <= 16'h0;
            r_state <= S_RD_HOLD;
          end
        end

        S_WR_HOLD: begin
          if (r_cnt == c_HOLD_LAST) begin
            r_cnt   <= 16'h0;
            r_state <= S_WR_CSB_LO;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end

        // A controller edge always wins over a timeout landing in the same cycle.
        S_WR_CSB_LO: begin
          if (!bus.ctrl_csb) begin
            r_start <= 1'b0;
            r_mode  <= 2'b00;
            r_cnt   <= 16'h0;
            r_state <= S_WR_CSB_HI;
          end else if (w_timeout) begin
            r_err   <= 2'b10;
            r_start <= 1'b0;
            r_mode  <= 2'b00;
            r_busy  <= 1'b0;
            r_cnt   <= 16'h0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end

        S_WR_CSB_HI: begin
          if (bus.ctrl_csb) begin
            r_cnt   <= 16'h0;
            r_state <= S_WR_PWR_OFF;
          end else if (w_timeout) begin
            r_err   <= 2'b10;
            r_busy  <= 1'b0;
            r_cnt   <= 16'h0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end

        S_WR_PWR_OFF: begin
          if (bus.ctrl_short) begin
            r_locked <= 1'b1;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_cnt    <= 16'h0;
            r_state  <= S_DONE;
          end else if (w_timeout) begin
            r_err   <= 2'b10;
            r_busy  <= 1'b0;
            r_cnt   <= 16'h0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end

        S_RD_HOLD: begin
          if (r_cnt == c_RD_LAST) begin
            r_rd_data <= bus.efuse_q;
            r_mode    <= 2'b00;
            r_cnt     <= 16'h0;
            r_state   <= S_RD_END;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end

        S_RD_END: begin
          if (bus.ctrl_csb || (r_cnt == c_RDEND_LAST)) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_cnt   <= 16'h0;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end

        S_DONE: begin
          r_cnt   <= 16'h0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.start       = r_start;
  assign bus.mode        = r_mode;
  assign bus.prog        = r_prog;
  assign bus.TCKHP       = r_tckhp;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.err         = r_err;
  assign bus.rd_data     = r_rd_data;
  assign bus.prog_locked = r_locked;

endmodule

`default_nettype wire

// File: tb/tb_efuse_prog_sequencer.sv
// ============================================================================
// Module  : tb_efuse_prog_sequencer
// Purpose : Self-checking bench for efuse_prog_sequencer with a completion scoreboard
// Revision: 1.0
// ============================================================================
`timescale 1ns/100ps
`default_nettype none

module tb_efuse_prog_sequencer;

  localparam logic [31:0] c_KEY = 32'hE5F0_C0DE;
  localparam int c_HOLD = 16;
  localparam int c_RDW  = 64;
  localparam int c_TO   = 4096;
  localparam logic [75:0] c_RST_VEC =
    {1'b0, 2'b00, 32'h0, 4'd4, 1'b0, 1'b0, 2'b00, 32'h0, 1'b0};

  typedef struct packed {
    logic [1:0]  err;
    logic [31:0] rd;
    logic        locked;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t exp_q[$];

  efuse_prog_sequencer_if bus();

  efuse_prog_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #12.5 clk = ~clk;

  function automatic logic [75:0] out_vec();
    return {bus.start, bus.mode, bus.prog, bus.TCKHP, bus.busy, bus.done,
            bus.err, bus.rd_data, bus.prog_locked};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic pulse_req(input bit p, input bit r, input logic [31:0] key,
                           input logic [31:0] data, input logic [3:0] cfg);
    bus.req_prog   = p;
    bus.req_read   = r;
    bus.unlock_key = key;
    bus.prog_data  = data;
    bus.tckhp_cfg  = cfg;
    tick();
    bus.req_prog = 1'b0;
    bus.req_read = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (out_vec() !== c_RST_VEC) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected %h", out_vec(), c_RST_VEC);
    end
  endtask

  task automatic test_bad_key();
    exp_t e;
    bit   launched;
    launched = 1'b0;
    exp_q.push_back('{err: 2'b01, rd: 32'h0, locked: 1'b0});
    pulse_req(1'b1, 1'b0, 32'h0, 32'hA5A5_0001, 4'd4);
    e = exp_q.pop_front();
    checks++;
    if ({bus.err, bus.rd_data, bus.prog_locked} !== e) begin
      errors++;
      $display("FAIL bad_key_status: got %h expected %h",
               {bus.err, bus.rd_data, bus.prog_locked}, e);
    end
    for (int i = 0; i < 4; i++) begin
      if (bus.start || bus.busy) launched = 1'b1;
      tick();
    end
    checks++;
    if (launched !== 1'b0) begin
      errors++;
      $display("FAIL bad_key_no_launch: got %b expected 0", launched);
    end
    // Correct key but an all-zero word is refused too.
    exp_q.push_back('{err: 2'b01, rd: 32'h0, locked: 1'b0});
    pulse_req(1'b1, 1'b0, c_KEY, 32'h0, 4'd4);
    e = exp_q.pop_front();
    checks++;
    if ({bus.err, bus.rd_data, bus.prog_locked, bus.busy} !== {e, 1'b0}) begin
      errors++;
      $display("FAIL zero_data_status: got %h expected %h",
               {bus.err, bus.rd_data, bus.prog_locked, bus.busy}, {e, 1'b0});
    end
  endtask

  task automatic test_collision();
    exp_q.push_back('{err: 2'b11, rd: 32'h0, locked: 1'b0});
    pulse_req(1'b1, 1'b1, c_KEY, 32'h1234_0001, 4'd4);
    begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if ({bus.err, bus.rd_data, bus.prog_locked, bus.busy, bus.mode} !== {e, 1'b0, 2'b00}) begin
        errors++;
        $display("FAIL collision_status: got %h expected %h",
                 {bus.err, bus.rd_data, bus.prog_locked, bus.busy, bus.mode}, {e, 1'b0, 2'b00});
      end
    end
  endtask

  task automatic test_program();
    int   n;
    bit   bad_mode;
    bit   got_done;
    exp_t e;
    bad_mode = 1'b0;
    got_done = 1'b0;
    exp_q.push_back('{err: 2'b00, rd: 32'h0, locked: 1'b1});
    bus.ctrl_csb   = 1'b0;
    bus.ctrl_short = 1'b0;
    pulse_req(1'b1, 1'b0, c_KEY, 32'hA5A5_0001, 4'd4);
    checks++;
    if ({bus.err, bus.prog, bus.TCKHP, bus.busy} !== {2'b00, 32'hA5A5_0001, 4'd4, 1'b1}) begin
      errors++;
      $display("FAIL prog_launch: got %h expected %h",
               {bus.err, bus.prog, bus.TCKHP, bus.busy}, {2'b00, 32'hA5A5_0001, 4'd4, 1'b1});
    end
    n = 0;
    while (bus.start && n < 100) begin
      n++;
      if (bus.mode !== 2'b01) bad_mode = 1'b1;
      tick();
    end
    // CSB is already low, so start drops on the first cycle after the hold window.
    checks++;
    if (n != c_HOLD + 1 || bad_mode) begin
      errors++;
      $display("FAIL prog_start_hold: got %0d cycles (bad_mode=%b) expected %0d",
               n, bad_mode, c_HOLD + 1);
    end
    checks++;
    if ({bus.mode, bus.busy, bus.done} !== {2'b00, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL prog_after_csb_lo: got %h expected %h",
               {bus.mode, bus.busy, bus.done}, {2'b00, 1'b1, 1'b0});
    end
    bus.ctrl_csb = 1'b1;
    tick();
    bus.ctrl_short = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.done) begin
        got_done = 1'b1;
        break;
      end
    end
    checks++;
    if (got_done !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL prog_done: got done=%b busy=%b expected done=1 busy=0", got_done, bus.busy);
    end
    e = exp_q.pop_front();
    checks++;
    if ({bus.err, bus.rd_data, bus.prog_locked} !== e) begin
      errors++;
      $display("FAIL prog_status: got %h expected %h",
               {bus.err, bus.rd_data, bus.prog_locked}, e);
    end
    tick();
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL prog_done_width: got %b expected 0", bus.done);
    end
  endtask

  task automatic test_locked();
    exp_t e;
    exp_q.push_back('{err: 2'b11, rd: 32'h0, locked: 1'b1});
    pulse_req(1'b1, 1'b0, c_KEY, 32'h1234_5678, 4'd7);
    e = exp_q.pop_front();
    checks++;
    if ({bus.err, bus.rd_data, bus.prog_locked} !== e) begin
      errors++;
      $display("FAIL locked_status: got %h expected %h",
               {bus.err, bus.rd_data, bus.prog_locked}, e);
    end
    checks++;
    if ({bus.busy, bus.start, bus.prog, bus.TCKHP} !== {1'b0, 1'b0, 32'hA5A5_0001, 4'd4}) begin
      errors++;
      $display("FAIL locked_no_launch: got %h expected %h",
               {bus.busy, bus.start, bus.prog, bus.TCKHP}, {1'b0, 1'b0, 32'hA5A5_0001, 4'd4});
    end
  endtask

  task automatic do_read(input logic [31:0] word, input logic csb, input int end_cycles,
                         input string name);
    int   n;
    bit   got_done;
    exp_t e;
    got_done = 1'b0;
    exp_q.push_back('{err: 2'b00, rd: word, locked: 1'b1});
    bus.efuse_q  = 32'h0;
    bus.ctrl_csb = csb;
    pulse_req(1'b0, 1'b1, 32'h0, 32'h0, 4'd9);
    checks++;
    if ({bus.err, bus.TCKHP, bus.busy, bus.start} !== {2'b00, 4'd9, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL %s_launch: got %h expected %h", name,
               {bus.err, bus.TCKHP, bus.busy, bus.start}, {2'b00, 4'd9, 1'b1, 1'b0});
    end
    n = 0;
    while (bus.mode == 2'b10 && n < 200) begin
      n++;
      if (n == 10) bus.efuse_q = word;
      tick();
    end
    checks++;
    if (n != c_RDW) begin
      errors++;
      $display("FAIL %s_window: got %0d cycles expected %0d", name, n, c_RDW);
    end
    bus.efuse_q = 32'hFFFF_0000;
    n = 0;
    while (n < 8) begin
      tick();
      n++;
      if (bus.done) begin
        got_done = 1'b1;
        break;
      end
    end
    checks++;
    if (!got_done || n != end_cycles || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_end: got done=%b after %0d busy=%b expected done after %0d busy=0",
               name, got_done, n, bus.busy, end_cycles);
    end
    e = exp_q.pop_front();
    checks++;
    if ({bus.err, bus.rd_data, bus.prog_locked} !== e) begin
      errors++;
      $display("FAIL %s_status: got %h expected %h", name,
               {bus.err, bus.rd_data, bus.prog_locked}, e);
    end
    tick();
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL %s_done_width: got %b expected 0", name, bus.done);
    end
    bus.ctrl_csb = 1'b1;
  endtask

  task automatic test_read();
    do_read(32'hDEAD_BEEF, 1'b1, 1, "read");
  endtask

  task automatic test_back_to_back();
    // CSB never returns high, so the end phase runs its full two cycles.
    do_read(32'h1234_5678, 1'b0, 2, "read_csb_lo");
    do_read(32'h0BAD_F00D, 1'b1, 1, "read_again");
  endtask

  task automatic test_timeout();
    int   n;
    bit   saw_done;
    exp_t e;
    saw_done = 1'b0;
    apply_reset();
    exp_q.push_back('{err: 2'b10, rd: 32'h0, locked: 1'b0});
    bus.ctrl_csb   = 1'b1;
    bus.ctrl_short = 1'b0;
    pulse_req(1'b1, 1'b0, c_KEY, 32'h0000_00FF, 4'd4);
    n = 0;
    while (bus.busy && n < 5000) begin
      n++;
      if (bus.done) saw_done = 1'b1;
      tick();
    end
    checks++;
    if (n != c_HOLD + c_TO + 1) begin
      errors++;
      $display("FAIL timeout_cycles: got %0d expected %0d", n, c_HOLD + c_TO + 1);
    end
    e = exp_q.pop_front();
    checks++;
    if ({bus.err, bus.rd_data, bus.prog_locked} !== e) begin
      errors++;
      $display("FAIL timeout_status: got %h expected %h",
               {bus.err, bus.rd_data, bus.prog_locked}, e);
    end
    checks++;
    if ({bus.mode, bus.start, bus.done, saw_done} !== 5'b0) begin
      errors++;
      $display("FAIL timeout_outputs: got mode=%b start=%b done=%b saw_done=%b expected all 0",
               bus.mode, bus.start, bus.done, saw_done);
    end
    bus.ctrl_short = 1'b1;
  endtask

  task automatic test_reset_midop();
    int n;
    bus.ctrl_csb   = 1'b0;
    bus.ctrl_short = 1'b0;
    pulse_req(1'b1, 1'b0, c_KEY, 32'h5555_AAAA, 4'd3);
    n = 0;
    while (bus.start && n < 100) begin
      n++;
      tick();
    end
    repeat (2) tick();
    checks++;
    if ({bus.busy, bus.start, bus.prog} !== {1'b1, 1'b0, 32'h5555_AAAA}) begin
      errors++;
      $display("FAIL midop_busy: got %h expected %h",
               {bus.busy, bus.start, bus.prog}, {1'b1, 1'b0, 32'h5555_AAAA});
    end
    rst = 1'b0;
    #2;
    checks++;
    if (out_vec() !== c_RST_VEC) begin
      errors++;
      $display("FAIL midop_async_reset: got %h expected %h", out_vec(), c_RST_VEC);
    end
    bus.ctrl_csb   = 1'b1;
    bus.ctrl_short = 1'b1;
    tick();
    rst = 1'b1;
    repeat (2) tick();
    checks++;
    if (out_vec() !== c_RST_VEC) begin
      errors++;
      $display("FAIL midop_after_release: got %h expected %h", out_vec(), c_RST_VEC);
    end
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    rst            = 1'b0;
    bus.req_prog   = 1'b0;
    bus.req_read   = 1'b0;
    bus.unlock_key = 32'h0;
    bus.prog_data  = 32'h0;
    bus.tckhp_cfg  = 4'd0;
    bus.efuse_q    = 32'h0;
    bus.ctrl_csb   = 1'b1;
    bus.ctrl_short = 1'b1;
    apply_reset();

    test_reset();
    test_bad_key();
    test_collision();
    test_program();
    test_locked();
    test_read();
    test_back_to_back();
    test_timeout();
    test_reset_midop();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
